// File: rtl/data_mem_pkg.sv
// data_mem_pkg: func3 codes, responder state encoding and access-size decode
package data_mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
   // 0 marks the one code that has no width at all
   function automatic logic [3:0] size_bytes(input logic [2:0] f3);
      return f3 == 3'b111 ? 4'd0 : 4'd1 << f3[1:0];
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: extracts/extends load lanes and merges store lanes into a 64-bit word
module mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [63:0] word_i,
   input  logic [63:0] wdata_i,
   input  logic [2:0]  off_i,
   input  logic [2:0]  func3_i,
   output logic [63:0] ld_o,
   output logic [63:0] st_o
);
   logic [63:0] sh, wsh;
   logic [7:0]  bm;
   always_comb begin
      sh = word_i >> {off_i, 3'b000};
      case (func3_i)
         F3_B:    ld_o = {{56{sh[7]}}, sh[7:0]};
         F3_H:    ld_o = {{48{sh[15]}}, sh[15:0]};
         F3_W:    ld_o = {{32{sh[31]}}, sh[31:0]};
         F3_D:    ld_o = sh;
         F3_BU:   ld_o = {56'd0, sh[7:0]};
         F3_HU:   ld_o = {48'd0, sh[15:0]};
         F3_WU:   ld_o = {32'd0, sh[31:0]};
         default: ld_o = '0;
      endcase
   end
   always_comb begin
      wsh = wdata_i << {off_i, 3'b000};
      bm = 8'((9'd1 << size_bytes(func3_i)) - 9'd1) << off_i;
      st_o = word_i;
      for (int i = 0; i < 8; i++) st_o[8*i +: 8] = bm[i] ? wsh[8*i +: 8] : word_i[8*i +: 8];
   end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder over a 64-bit RAM
// with configurable access latency and misalign/range/func3 error reporting.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 512,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            we_q;
   logic [2:0]      f3_q;
   logic [31:0]     addr_q;
   logic [63:0]     wdata_q, rdata_q;
   logic            err_q;
   logic [63:0]     mem [DEPTH_WORDS];
   logic [63:0]     old_word, ld_data, st_word;
   logic            accept, fire, illegal, misal, oor, err;
   assign accept   = req_valid && req_ready;
   assign fire     = state_q == ST_ACCESS && cnt_q == '0;
   assign old_word = mem[addr_q[3 +: AW]];
   assign illegal  = we_q ? f3_q[2] : f3_q == 3'b111;
   assign misal    = |(addr_q[2:0] & 3'(size_bytes(f3_q) - 4'd1));
   assign oor      = addr_q[31:3] >= 29'(DEPTH_WORDS);
   assign err      = illegal || misal || oor;
   mem_lane_align u_align (
      .word_i  (old_word),
      .wdata_i (wdata_q),
      .off_i   (addr_q[2:0]),
      .func3_i (f3_q),
      .ld_o    (ld_data),
      .st_o    (st_word)
   );
   always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
   always_comb begin
      state_d = state_q == ST_IDLE   ? (req_valid ? ST_ACCESS : ST_IDLE) :
                state_q == ST_ACCESS ? (fire ? ST_RESP : ST_ACCESS) :
                                       (resp_ready ? ST_IDLE : ST_RESP);
   end
   always_comb begin
      req_ready  = state_q == ST_IDLE && !rst;
      resp_valid = state_q == ST_RESP;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         cnt_q   <= CW'(LATENCY - 1);
         we_q    <= req_we;
         f3_q    <= req_func3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end else if (fire) begin
         rdata_q <= err || we_q ? 64'd0 : ld_data;
         err_q   <= err;
      end else if (state_q == ST_ACCESS) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end
   // RAM contents survive reset; only a store reaching its commit edge writes
   always_ff @(posedge clk) begin
      if (!rst && fire && we_q && !err) mem[addr_q[3 +: AW]] <= st_word;
   end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder on the memory side of the CPU's load/store path. It accepts one load or store request at a time from the load/store unit and performs it against an internal 64-bit-wide RAM. It handles RV64 byte, half, word and double widths with sign or zero extension. It returns the read data or a write acknowledgement through a valid/ready response channel and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- DEPTH_WORDS, 512: number of 64-bit RAM words; power of two.
- LATENCY, 2: cycles spent in ACCESS; must be 1 or more.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV64 width/sign code (instr[14:12]).
- req_addr  in  32  byte address.
- req_wdata  in  64  store data, right-aligned (rs2).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  64  load result, already extended; 0 for stores and errors.
- resp_err  out  1  access was misaligned, out of range, or had an illegal func3.

## Operation
- There are three states: IDLE, ACCESS and RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture we, func3, addr and wdata, load cnt = LATENCY-1, and go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - When cnt = 0: perform the access, register resp_rdata and resp_err, and go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE.
- func3 for loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; 111 is illegal.
- func3 for stores: 000 SB, 001 SH, 010 SW, 011 SD; 1xx is illegal.
- Word index is addr[3 +: log2(DEPTH_WORDS)]. Lane offset is addr[2:0].
- Out of range: (addr >> 3) >= DEPTH_WORDS.
- Misaligned:
  - Half: addr[0] != 0.
  - Word: addr[1:0] != 0.
  - Double: addr[2:0] != 0.
- Load:
  - Select the lane at byte offset addr[2:0] of the selected size.
  - Signed codes sign-extend to 64 bits; U codes zero-extend.
- Store:
  - Read-modify-write of the selected word.
  - Only the addressed byte lanes are replaced, with the low bytes of wdata; the other lanes are preserved.
- Error (any illegal func3, misalignment or range fault):
  - No RAM write.
  - resp_rdata = 0, resp_err = 1.
- RAM contents are not reset.

## Timing
- Reset values: req_ready = 0 while rst is high, then 1 in IDLE. resp_valid = 0, resp_rdata = 0, resp_err = 0. State is IDLE and cnt = 0.
- Request accepted at edge E:
  - resp_valid goes high after edge E+LATENCY.
  - A store commits to RAM at edge E+LATENCY.
- If resp_ready is already high, the response handshake occurs at edge E+LATENCY+1. req_ready rises after that edge.
- Minimum request spacing is LATENCY+2 cycles. A response handshake and a new request cannot be accepted in the same cycle.
- Back-pressure: resp_valid, resp_rdata and resp_err are held indefinitely while resp_ready = 0.
- req_* inputs are ignored outside the IDLE handshake. The requester may change them freely after acceptance.
- Reset mid-operation:
  - All outputs return to their reset values on the next edge and the state returns to IDLE.
  - A store not yet at its commit edge is dropped.
  - A store already committed stays committed.
- Load after store to the same word with no intervening reset returns the new data.

## Structure
- Package data_mem_pkg holds the func3 localparams (F3_B … F3_WU), the state encoding (ST_IDLE, ST_ACCESS, ST_RESP), and a size-decode function that maps func3 to a byte count.
- Sub-module mem_lane_align is purely combinational. It has two paths:
  - Load: extract and extend (word, offset, func3) → 64-bit result.
  - Store: merge (old word, wdata, offset, func3) → new word.
- The responder top holds the FSM, counter, capture registers and RAM array.

## Test plan
- SD 0xDEADBEEF_CAFEF00D to addr 0x10, then LD from 0x10 → resp_rdata = 0xDEADBEEFCAFEF00D, resp_err = 0; resp_valid rises LATENCY cycles after each accept.
- After the above, SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFFFFFFFFFF80, LBU 0x13 → 0x80, LD 0x10 → 0xDEADBEEF80FEF00D.
- LW 0x12 or SH 0x11 → resp_err = 1, resp_rdata = 0; a following LD 0x10 shows the RAM unchanged.
- LD at byte address DEPTH_WORDS*8 → resp_err = 1; load with func3 = 111 → resp_err = 1.
- Hold resp_ready = 0 for 10 cycles → resp_valid and data remain stable and req_ready stays 0. Then pulse resp_ready → req_ready = 1 on the next cycle.
- Issue SD 0x1111 to 0x20 (old word 0x2222), then assert rst one cycle after acceptance with LATENCY = 2 → outputs are zero and the state is IDLE. A following LD 0x20 returns 0x2222.
